// File: rtl/ifetch.sv
// ifetch: fetch PC, single-outstanding memory request and parcel queue.
// Define IFETCH_WIDE_EN for 32-bit fetches that return two parcels.
module ifetch #(
    parameter int            RV       = 32,
    parameter int            QDEPTH   = 4,
    parameter logic [RV-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    output logic          ireq,
    output logic [RV-1:0] iaddr,
    input  logic          iack,
`ifdef IFETCH_WIDE_EN
    input  logic [31:0]   irdata,
`else
    input  logic [15:0]   irdata,
`endif
    input  logic          redirect,
    input  logic [RV-1:0] redirect_pc,
    input  logic          stall,
    output logic [15:0]   ins,
    output logic [RV-1:0] ins_pc,
    output logic          idone
);
    localparam int AW = $clog2(QDEPTH);
    localparam int PW = AW + 1;
`ifdef IFETCH_WIDE_EN
    localparam int PPR = 2;
`else
    localparam int PPR = 1;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DISCARD} state_t;

    state_t        state, state_n;
    logic [RV-1:0] fpc, fpc_n;
    logic [RV-1:0] req_addr, fetch_addr;
    logic [PW-1:0] wr, rd, count, occ;
    logic [AW-1:0] wr1;
    logic [15:0]   q_ins [QDEPTH];
    logic [RV-1:0] q_pc  [QDEPTH];
    logic          empty, pop, push, room, req;
    logic [1:0]    npush;
    logic [15:0]   p_ins0, p_ins1;
    logic [RV-1:0] p_pc1;

`ifdef IFETCH_WIDE_EN
    assign fetch_addr = {fpc[RV-1:2], 2'b00};
    assign p_ins0     = fpc[1] ? irdata[31:16] : irdata[15:0];
    assign p_ins1     = irdata[31:16];
    assign npush      = fpc[1] ? 2'd1 : 2'd2;
    assign fpc_n      = fetch_addr + RV'(4);
`else
    assign fetch_addr = fpc;
    assign p_ins0     = irdata;
    assign p_ins1     = irdata;
    assign npush      = 2'd1;
    assign fpc_n      = fpc + RV'(2);
`endif
    assign p_pc1 = fpc + RV'(2);

    assign count = wr - rd;
    assign empty = (count == '0);
    assign pop   = !empty && !stall && !redirect && !reset;
    assign idone = pop;
    // room is judged on the occupancy left after this cycle's pop
    assign occ   = count - PW'(pop);
    assign room  = int'(occ) <= QDEPTH - PPR;
    assign wr1   = wr[AW-1:0] + AW'(1);

    assign ins    = q_ins[rd[AW-1:0]];
    assign ins_pc = q_pc[rd[AW-1:0]];
    assign ireq   = req;
    assign iaddr  = (state == IDLE) ? fetch_addr : req_addr;

    always_comb begin
        state_n = state;
        req     = 1'b0;
        push    = 1'b0;
        if (!reset) begin
            unique case (state)
                IDLE: begin
                    if (!redirect && room) begin
                        req = 1'b1;
                        if (iack) push = 1'b1;
                        else state_n = BUSY;
                    end
                end
                BUSY: begin
                    req = 1'b1;
                    if (iack) begin
                        push    = !redirect;
                        state_n = IDLE;
                    end else if (redirect) begin
                        state_n = DISCARD;
                    end
                end
                DISCARD: begin
                    req = 1'b1;
                    if (iack) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            fpc      <= {RESET_PC[RV-1:1], 1'b0};
            req_addr <= '0;
            wr       <= '0;
            rd       <= '0;
        end else begin
            state <= state_n;
            if (req && state == IDLE) req_addr <= fetch_addr;
            if (redirect) begin
                fpc <= {redirect_pc[RV-1:1], 1'b0};
                wr  <= '0;
                rd  <= '0;
            end else begin
                if (push) begin
                    fpc <= fpc_n;
                    wr  <= wr + PW'(npush);
                end
                if (pop) rd <= rd + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_ins[wr[AW-1:0]] <= p_ins0;
            q_pc[wr[AW-1:0]]  <= fpc;
            if (npush == 2'd2) begin
                q_ins[wr1] <= p_ins1;
                q_pc[wr1]  <= p_pc1;
            end
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed vector table plus randomized run against a
// program-order reference model of the fetch stream.
module tb_ifetch;
    localparam int QD = 4;

    function automatic logic [15:0] mem16(input logic [31:0] a);
        return a[16:1] ^ 16'h5A3C;
    endfunction

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        iack = 1'b0;
    logic        redirect = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        ireq, idone;
    logic [31:0] iaddr, ins_pc;
    logic [15:0] ins;
`ifdef IFETCH_WIDE_EN
    logic [31:0] irdata;
    assign irdata = {mem16(iaddr + 32'd2), mem16(iaddr)};
`else
    logic [15:0] irdata;
    assign irdata = mem16(iaddr);
`endif

    ifetch #(.RV(32), .QDEPTH(QD), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .ireq(ireq), .iaddr(iaddr),
        .iack(iack), .irdata(irdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .stall(stall), .ins(ins),
        .ins_pc(ins_pc), .idone(idone)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %0s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic a, input logic s,
                         input logic d, input logic [31:0] p);
        @(posedge clk);
        #1;
        reset = r; iack = a; stall = s; redirect = d; redirect_pc = p;
        #4;
    endtask

    typedef struct {
        logic        rst, ack, stl, rdr;
        logic [31:0] rpc;
        int          req;
        logic [31:0] addr;
        logic        done;
        logic [31:0] pc;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic a,
        input logic s, input logic d, input logic [31:0] p,
        input int q, input logic [31:0] ad, input logic dn,
        input logic [31:0] pc);
        vec_t v;
        v.rst = r; v.ack = a; v.stl = s; v.rdr = d; v.rpc = p;
        v.req = q; v.addr = ad; v.done = dn; v.pc = pc;
        return v;
    endfunction

    localparam int NV = 29;
    vec_t tab [NV];

    logic [31:0] q[$];
    logic [31:0] nf, held, tmp;
    int          epoch, req_ep, olen, ndone;
    bit          outst, ed;

    initial begin
`ifdef IFETCH_WIDE_EN
        drive(1, 0, 0, 0, 0);
        chk("w rst ireq", 32'(ireq), 0);
        drive(0, 0, 0, 1, 32'h102);
        chk("w rdr idone", 32'(idone), 0);
        drive(0, 1, 0, 0, 0);
        chk("w ireq", 32'(ireq), 1);
        chk("w iaddr", iaddr, 32'h100);
        chk("w idone0", 32'(idone), 0);
        drive(0, 0, 0, 0, 0);
        chk("w idone1", 32'(idone), 1);
        chk("w ins_pc", ins_pc, 32'h102);
        chk("w ins", 32'(ins), 32'(mem16(32'h102)));
        chk("w next ireq", 32'(ireq), 1);
        chk("w next iaddr", iaddr, 32'h104);
        drive(0, 0, 0, 0, 0);
        chk("w empty", 32'(idone), 0);
`else
        // ireq code 2 = not checked (redirect cycles in IDLE)
        tab[0]  = mk(1, 0, 0, 0, 0,            0, 0,            0, 0);
        tab[1]  = mk(0, 1, 0, 0, 0,            1, 0,            0, 0);
        tab[2]  = mk(0, 1, 0, 0, 0,            1, 2,            1, 0);
        tab[3]  = mk(0, 1, 0, 0, 0,            1, 4,            1, 2);
        tab[4]  = mk(0, 1, 1, 0, 0,            1, 6,            0, 0);
        tab[5]  = mk(0, 1, 1, 0, 0,            1, 8,            0, 0);
        tab[6]  = mk(0, 1, 1, 0, 0,            1, 10,           0, 0);
        tab[7]  = mk(0, 1, 1, 0, 0,            0, 0,            0, 0);
        tab[8]  = mk(0, 1, 0, 0, 0,            1, 12,           1, 4);
        tab[9]  = mk(0, 1, 0, 0, 0,            1, 14,           1, 6);
        tab[10] = mk(0, 0, 0, 0, 0,            1, 16,           1, 8);
        tab[11] = mk(0, 1, 0, 1, 32'h101,      1, 16,           0, 0);
        tab[12] = mk(0, 1, 0, 0, 0,            1, 32'h100,      0, 0);
        tab[13] = mk(0, 1, 0, 0, 0,            1, 32'h102,      1, 32'h100);
        tab[14] = mk(0, 0, 0, 0, 0,            1, 32'h104,      1, 32'h102);
        tab[15] = mk(0, 0, 0, 1, 32'h200,      1, 32'h104,      0, 0);
        tab[16] = mk(0, 0, 0, 0, 0,            1, 32'h104,      0, 0);
        tab[17] = mk(0, 1, 0, 0, 0,            1, 32'h104,      0, 0);
        tab[18] = mk(0, 1, 0, 0, 0,            1, 32'h200,      0, 0);
        tab[19] = mk(0, 1, 0, 0, 0,            1, 32'h202,      1, 32'h200);
        tab[20] = mk(0, 0, 1, 0, 0,            1, 32'h204,      0, 0);
        tab[21] = mk(1, 0, 0, 0, 0,            0, 0,            0, 0);
        tab[22] = mk(0, 1, 0, 0, 0,            1, 0,            0, 0);
        tab[23] = mk(0, 1, 0, 0, 0,            1, 2,            1, 0);
        tab[24] = mk(0, 0, 0, 1, 32'hFFFFFFFE, 2, 0,            0, 0);
        tab[25] = mk(0, 1, 0, 0, 0,            1, 32'hFFFFFFFE, 0, 0);
        tab[26] = mk(0, 1, 0, 0, 0,            1, 0,            1, 32'hFFFFFFFE);
        tab[27] = mk(0, 0, 0, 0, 0,            1, 2,            1, 0);
        tab[28] = mk(0, 0, 0, 0, 0,            1, 2,            0, 0);

        for (int i = 0; i < NV; i++) begin
            drive(tab[i].rst, tab[i].ack, tab[i].stl, tab[i].rdr, tab[i].rpc);
            if (tab[i].req != 2)
                chk($sformatf("v%0d ireq", i), 32'(ireq), 32'(tab[i].req));
            if (tab[i].req == 1)
                chk($sformatf("v%0d iaddr", i), iaddr, tab[i].addr);
            chk($sformatf("v%0d idone", i), 32'(idone), 32'(tab[i].done));
            if (tab[i].done) begin
                chk($sformatf("v%0d ins_pc", i), ins_pc, tab[i].pc);
                chk($sformatf("v%0d ins", i), 32'(ins), 32'(mem16(tab[i].pc)));
            end
        end

        drive(1, 0, 0, 0, 0);
        q.delete(); nf = 0; epoch = 0; req_ep = -1;
        outst = 0; olen = 0; ndone = 0; held = 0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            reset    = ($urandom_range(0, 299) == 0);
            stall    = ($urandom_range(0, 9) < 3);
            redirect = ($urandom_range(0, 39) == 0);
            redirect_pc = $urandom();
            if ($urandom_range(0, 3) == 0)
                redirect_pc = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
            iack = 1'($urandom_range(0, 1));
            #4;
            if (reset) begin
                chk("rst ireq", 32'(ireq), 0);
                chk("rst idone", 32'(idone), 0);
                q.delete(); nf = 0; outst = 0; olen = 0; epoch++;
            end else begin
                ed = (q.size() > 0) && !stall && !redirect;
                chk("idone", 32'(idone), 32'(ed));
                if (ed) begin
                    tmp = q.pop_front();
                    chk("ins_pc", ins_pc, tmp);
                    chk("ins", 32'(ins), 32'(mem16(tmp)));
                    ndone++;
                end
                if (outst) begin
                    chk("held ireq", 32'(ireq), 1);
                    chk("held iaddr", iaddr, held);
                end else if (!redirect) begin
                    chk("room ireq", 32'(ireq), 32'(q.size() < QD));
                    if (ireq) chk("fetch addr", iaddr, nf);
                end
                if (ireq && !outst) begin
                    held = iaddr;
                    req_ep = epoch;
                end
                if (ireq) begin
                    if (iack) begin
                        outst = 0; olen = 0;
                        if (!redirect && req_ep == epoch) begin
                            q.push_back(nf);
                            nf = nf + 32'd2;
                        end
                    end else begin
                        outst = 1; olen++;
                    end
                end
                if (olen > 40) begin
                    chk("ack timeout", 32'(olen), 0);
                    olen = 0; outst = 0;
                end
                if (redirect) begin
                    q.delete();
                    nf = redirect_pc & ~32'd1;
                    epoch++;
                end
            end
        end
        chk("throughput", 32'(ndone > 300), 1);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
